pll_reset_sequencer: RTL
========================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before reset hold begins (min 1).
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 16: cycles sys_rst stays asserted after stable lock or reset request (min 1).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 65536: consecutive high cycles that qualify rst_req (used only with DEBOUNCE_EN).
REQ-004 clk  input  1  system clock from femtoPLL output; one clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pll_locked  input  1  PLL lock flag, asynchronous to clk.
REQ-007 rst_req  input  1  user reset request (button), asynchronous, active-high.
REQ-008 sys_rst  output  1  registered active-high reset to the core.
REQ-009 sys_ready  output  1  registered; high only in RUN.
REQ-010 lock_lost  output  1  registered one-cycle pulse on lock loss from HOLD or RUN.
REQ-011 state  output  2  current FSM state for debug.

Function
REQ-012 pll_locked and rst_req SHALL each pass through a 2-flop synchronizer; all FSM decisions use synchronized values (lock_s, req_s).
REQ-013 FSM states SHALL be WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3.
REQ-014 WAIT_LOCK: lock_s=1 -> STABILIZE with counter cleared; else stay.
REQ-015 STABILIZE: counter increments each cycle; lock_s=0 -> WAIT_LOCK; counter==LOCK_STABLE_CYCLES-1 with lock_s=1 -> HOLD, counter cleared.
REQ-016 HOLD: counter increments; counter==RST_HOLD_CYCLES-1 -> RUN; qualified request restarts counter at 0; lock_s=0 -> WAIT_LOCK.
REQ-017 RUN: lock_s=0 -> WAIT_LOCK; qualified request -> HOLD, counter cleared.
REQ-018 Lock loss SHALL take priority over a simultaneous qualified request in every state.
REQ-019 lock_lost SHALL pulse for exactly one cycle, the cycle after leaving HOLD or RUN because of lock_s=0; never from STABILIZE.
REQ-020 sys_rst SHALL be 0 exactly when registered state is RUN; sys_ready SHALL be its complement; both registered, no combinational path from inputs.
REQ-021 With pll_locked constantly high, sys_ready SHALL rise exactly 3+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES cycles after the first edge sampling pll_locked=1.
REQ-022 Counter width SHALL be $clog2 of the largest of the three counts, +1; counter SHALL never wrap.
REQ-023 A qualified request SHALL be a single event: another requires req_s to go low first.

Reset
REQ-024 On reset=1 at a clk edge: state=WAIT_LOCK, counter=0, sys_rst=1, sys_ready=0, lock_lost=0, synchronizer and debounce flops 0.
REQ-025 Reset mid-operation (any state) SHALL abort and restart from WAIT_LOCK on the next edge; no lock_lost pulse.

Configuration
REQ-026 Macro PLL_RST_DEBOUNCE_EN defined: rst_req qualifies only after req_s is high for DEBOUNCE_CYCLES consecutive cycles; any low clears the debounce counter.
REQ-027 Macro PLL_RST_DEBOUNCE_EN undefined: rst_req qualifies on the first cycle req_s is high (rising edge); debounce counter not instantiated.

Structure
REQ-028 State encodings and the synchronizer depth (2) SHALL live in a shared package/header with the PLL-related definitions.
REQ-029 The 2-flop synchronizer SHALL be one sub-module, sync_2ff, instantiated twice.

Verification (LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, DEBOUNCE_CYCLES=4)
REQ-030 pll_locked held 1 after reset -> sys_rst falls and sys_ready rises exactly 15 cycles after first sampled lock; lock_lost stays 0.
REQ-031 pll_locked drops for 1 cycle at STABILIZE count 5 -> FSM returns to WAIT_LOCK, no lock_lost, full 8-cycle count restarts.
REQ-032 In RUN, pll_locked falls -> lock_lost one-cycle pulse 3 cycles later, sys_rst=1 same cycle, state=WAIT_LOCK.
REQ-033 In RUN, rst_req high 6 cycles (debounce on) -> HOLD, sys_rst high exactly 4 cycles, back to RUN; rst_req high 3 cycles -> no effect.
REQ-034 rst_req and pll_locked fall synchronized on the same cycle in RUN -> WAIT_LOCK with lock_lost pulse, not HOLD.
REQ-035 reset asserted in HOLD -> next cycle WAIT_LOCK, sys_rst=1, counter 0, lock_lost=0.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer_pkg
// Description : Shared PLL reset-sequencer definitions. These are the FSM
//               state encodings, the synchronizer depth and the counter-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } pll_state_e;

    localparam int unsigned c_sync_stages = 2;

    // The extra bit leaves headroom so a terminal count never wraps.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Flop-chain synchronizer that brings an asynchronous level into
//               the clk domain. It clears on a synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff
    import pll_reset_sequencer_pkg::*;
#(
    parameter int unsigned STAGES = c_sync_stages
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], din};
        end
    end

    assign dout = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Sequences the core reset from the PLL lock flag and a user
//               reset request. Define PLL_RST_DEBOUNCE_EN to debounce rst_req.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned DEBOUNCE_CYCLES    = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       rst_req,
    output logic       sys_rst,
    output logic       sys_ready,
    output logic       lock_lost,
    output logic [1:0] state
);

    localparam int unsigned c_cnt_w = cnt_width(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES, DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(RST_HOLD_CYCLES - 1);

    logic               w_lock_s;
    logic               w_req_s;
    logic               w_req_q;
    logic               w_lock_loss;
    pll_state_e         r_state;
    pll_state_e         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_next_cnt;
    logic               r_lost_evt;

    sync_2ff u_sync_lock (
        .clk   (clk),
        .reset (reset),
        .din   (pll_locked),
        .dout  (w_lock_s)
    );

    sync_2ff u_sync_req (
        .clk   (clk),
        .reset (reset),
        .din   (rst_req),
        .dout  (w_req_s)
    );

`ifdef PLL_RST_DEBOUNCE_EN
    localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [c_cnt_w-1:0] r_deb_cnt;
    logic               r_deb_done;

    // The done flag makes one long press a single event until req_s drops.
    always_ff @(posedge clk) begin
        if (reset || !w_req_s) begin
            r_deb_cnt  <= '0;
            r_deb_done <= 1'b0;
        end else if (!r_deb_done) begin
            if (r_deb_cnt == c_deb_last) begin
                r_deb_done <= 1'b1;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    assign w_req_q = w_req_s && !r_deb_done && (r_deb_cnt == c_deb_last);
`else
    logic r_req_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_d <= 1'b0;
        end else begin
            r_req_d <= w_req_s;
        end
    end

    assign w_req_q = w_req_s && !r_req_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_WAIT_LOCK;
            r_cnt      <= '0;
            r_lost_evt <= 1'b0;
            sys_rst    <= 1'b1;
            sys_ready  <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_lost_evt <= w_lock_loss;
            // Outputs follow the registered state, which keeps inputs off them.
            sys_rst    <= (r_state != ST_RUN);
            sys_ready  <= (r_state == ST_RUN);
            lock_lost  <= r_lost_evt;
        end
    end

    // Lock loss is tested first in every state so it beats a request.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_lock_loss  = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next_state = ST_STABILIZE;
                    w_next_cnt   = '0;
                end
            end
            ST_STABILIZE: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_lock_last) begin
                    w_next_state = ST_HOLD;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cnt   = '0;
                    w_lock_loss  = 1'b1;
                end else if (w_req_q) begin
                    w_next_cnt = '0;
                end else if (r_cnt == c_hold_last) begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cnt   = '0;
                    w_lock_loss  = 1'b1;
                end else if (w_req_q) begin
                    w_next_state = ST_HOLD;
                    w_next_cnt   = '0;
                end
            end
            default: begin
                w_next_state = ST_WAIT_LOCK;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire
